// File: rtl/debounce_edge_det_if.sv
// Interface bundling the sample inputs and the debounced outputs of
// debounce_edge_det. The event-counter signal exists only when
// DB_EVT_CNT_EN is defined.
interface debounce_edge_det_if #(
  parameter int CNT_W = 8
);
  logic en;
  logic din;
  logic level;
  logic rise;
  logic fall;
  logic busy;
`ifdef DB_EVT_CNT_EN
  logic [CNT_W-1:0] evt_cnt;
`endif

  // Producer side: drives the sampled level and enable, observes the result.
  modport master (
    output en,
    output din,
    input  level,
    input  rise,
    input  fall,
`ifdef DB_EVT_CNT_EN
    input  evt_cnt,
`endif
    input  busy
  );

  // Debouncer side.
  modport slave (
    input  en,
    input  din,
    output level,
    output rise,
    output fall,
`ifdef DB_EVT_CNT_EN
    output evt_cnt,
`endif
    output busy
  );
endinterface

// File: rtl/debounce_edge_det.sv
// debounce_edge_det: glitch filter and edge detector for a level that has
// already passed through a 2-FF synchroniser. A change on din is accepted
// only after DB_CYCLES consecutive enabled samples at the new value; the
// accepted change updates level and fires a one-cycle rise or fall strobe.
// Optional feature macro: DB_EVT_CNT_EN adds a saturating rise+fall event
// counter (evt_cnt, CNT_W bits). Without it the counter is absent.
module debounce_edge_det #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  debounce_edge_det_if.slave bus
);

  // Qualification counter wide enough to hold DB_CYCLES.
  localparam int CW = $clog2(DB_CYCLES + 1);
  // Value of cnt on the sample that completes a qualification run.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          level;
  logic          rise;
  logic          fall;
  logic          busy;

  // Debounce FSM; level, strobes and busy are registered alongside the state.
  // Strobes default low every edge so they last exactly one cycle even when
  // en drops right after an accept. With en low everything else holds, so a
  // disabled sample neither advances nor breaks a qualification run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (bus.en) begin
        case (state)
          STABLE_LO: begin
            if (bus.din) begin
              state <= QUAL_HI;
              cnt   <= CW'(1);
              busy  <= 1'b1;
            end else begin
              cnt <= '0;
            end
          end
          QUAL_HI: begin
            if (!bus.din) begin
              // Candidate reverted before qualifying: drop it silently.
              state <= STABLE_LO;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_HI;
              cnt   <= '0;
              level <= 1'b1;
              rise  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STABLE_HI: begin
            if (!bus.din) begin
              state <= QUAL_LO;
              cnt   <= CW'(1);
              busy  <= 1'b1;
            end else begin
              cnt <= '0;
            end
          end
          QUAL_LO: begin
            if (bus.din) begin
              state <= STABLE_HI;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_LO;
              cnt   <= '0;
              level <= 1'b0;
              fall  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.level = level;
  assign bus.rise  = rise;
  assign bus.fall  = fall;
  assign bus.busy  = busy;

`ifdef DB_EVT_CNT_EN
  logic             accept;
  logic [CNT_W-1:0] evt_cnt;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // Flags the edge on which the FSM accepts a change (same edge as rise/fall).
  always_comb begin
    accept = 1'b0;
    if (bus.en && (cnt == CNT_LAST)) begin
      if ((state == QUAL_HI) && bus.din)
        accept = 1'b1;
      else if ((state == QUAL_LO) && !bus.din)
        accept = 1'b1;
    end
  end

  // Event counter; accept already implies en, so it holds while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      evt_cnt <= '0;
    else if (accept)
      evt_cnt <= sat_inc(evt_cnt);
  end

  assign bus.evt_cnt = evt_cnt;
`endif

endmodule
